fetch_queue: RTL and testbench

Instruction-fetch front end with a small prefetch FIFO. It sits directly upstream of the IF_ID pipeline register and replaces the bare PC/instruction-memory fetch. It keeps a fetch PC and issues one read per cycle to a synchronous instruction memory with 1-cycle latency. It buffers returned instructions with their PC+4 and presents them to IF_ID under a stall/flush protocol driven by the hazard unit and the Execute-stage branch resolution.

---
 rtl/fetch_queue.sv | 111 +++++++++++
 tb/tb_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction-fetch front end with a small prefetch FIFO feeding
//             IF_ID under a stall/flush protocol.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br,
    input  logic [31:0] br_pc,
    input  logic        stall,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        valid
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_issued_addr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_inflight;
    logic               r_kill;
    logic [31:0]        r_buf_pc  [DEPTH];
    logic [31:0]        r_buf_ins [DEPTH];

    logic [c_CNT_W-1:0] w_occupancy;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_head_valid;
    logic [31:0]        w_br_target;

    // Occupancy counts the in-flight read as a reserved slot, so a response
    // can always be absorbed without back-pressuring the memory.
    always_comb begin
        w_occupancy  = r_count + {{(c_CNT_W-1){1'b0}}, r_inflight};
        w_issue      = !rst && !br && (w_occupancy < c_DEPTH_CNT);
        w_push       = r_inflight && !r_kill && !br;
        w_head_valid = !rst && (r_count != '0);
        w_pop        = w_head_valid && !stall && !br;
        w_br_target  = br_pc & 32'hFFFF_FFFC;
    end

    assign imem_rd_en = w_issue;
    assign imem_addr  = r_fetch_pc;
    assign valid      = w_head_valid;
    assign ins        = w_head_valid ? r_buf_ins[r_rd_ptr] : 32'h0000_0000;
    assign pc         = w_head_valid ? r_buf_pc[r_rd_ptr]  : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_issued_addr <= 32'h0000_0000;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_kill        <= 1'b0;
        end else if (br) begin
            r_fetch_pc <= w_br_target;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_kill     <= r_inflight;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= 1'b0;
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_issued_addr <= r_fetch_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only read behind r_count.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_buf_pc[r_wr_ptr]  <= r_issued_addr + 32'd4;
            r_buf_ins[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue: directed vector table,
//             address-wrap sequence and randomized run against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] PC_A   = 32'h0000_0000;
    localparam logic [31:0] PC_B   = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        br;
    logic [31:0] br_pc;
    logic        stall;

    logic        rd_en_a, rd_en_b;
    logic [31:0] addr_a, addr_b;
    logic [31:0] rdata_a, rdata_b;
    logic [31:0] ins_a, ins_b;
    logic [31:0] pc_a, pc_b;
    logic        valid_a, valid_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(PC_A)) dut_a (
        .clk(clk), .rst(rst), .br(br), .br_pc(br_pc), .stall(stall),
        .imem_rd_en(rd_en_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .ins(ins_a), .pc(pc_a), .valid(valid_a)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(PC_B)) dut_b (
        .clk(clk), .rst(rst), .br(br), .br_pc(br_pc), .stall(stall),
        .imem_rd_en(rd_en_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .ins(ins_b), .pc(pc_b), .valid(valid_b)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    function automatic logic [31:0] wd(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    // Synchronous 1-cycle memories; idle cycles return garbage.
    always @(posedge clk) begin
        rdata_a <= rd_en_a ? word(addr_a) : $urandom();
        rdata_b <= rd_en_b ? word(addr_b) : $urandom();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] br_pc;
        logic        stall;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        e_rd_en;
        logic [31:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic b, input logic [31:0] bp,
                                input logic s, input logic ev, input logic [31:0] ep,
                                input logic [31:0] ei, input logic er, input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.br = b; v.br_pc = bp; v.stall = s;
        v.e_valid = ev; v.e_pc = ep; v.e_ins = ei; v.e_rd_en = er; v.e_addr = ea;
        return v;
    endfunction

    // Behavioural reference: a queue of {pc, ins} plus one outstanding read.
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_iaddr;
    bit          m_inflight;
    bit          m_kill;

    task automatic model_step(input logic r, input logic b, input logic [31:0] bp, input logic s);
        bit   do_pop;
        bit   do_issue;
        ent_t e;
        if (r) begin
            mq.delete();
            m_fetch = PC_A; m_inflight = 0; m_kill = 0;
        end else if (b) begin
            mq.delete();
            m_fetch = bp & 32'hFFFF_FFFC;
            m_kill = m_inflight; m_inflight = 0;
        end else begin
            do_pop   = (mq.size() > 0) && !s;
            do_issue = (mq.size() + int'(m_inflight)) < DEPTH;
            if (do_pop) void'(mq.pop_front());
            if (m_inflight && !m_kill) begin
                e.pc = m_iaddr + 32'd4; e.ins = word(m_iaddr);
                mq.push_back(e);
            end
            if (do_issue) begin
                m_iaddr = m_fetch; m_fetch = m_fetch + 32'd4;
            end
            m_inflight = do_issue; m_kill = 0;
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic        ev;
        logic        er;
        logic [31:0] ep, ei, ea;
        logic [31:0] wrap_addr [5];
        logic [31:0] wrap_pc   [5];
        logic [31:0] wrap_ins  [5];

        // Reset, stream, stall, branch, br+stall, back-to-back br, reset mid-stream.
        vecs.push_back(mk(1, 0, 0,        0, 0, 0,      0,        0, 0));
        vecs.push_back(mk(1, 0, 0,        0, 0, 0,      0,        0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,      0,        1, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,      0,        1, 4));
        vecs.push_back(mk(0, 0, 0,        0, 1, 4,      wd(0),    1, 8));
        vecs.push_back(mk(0, 0, 0,        1, 1, 8,      wd(1),    1, 12));
        vecs.push_back(mk(0, 0, 0,        1, 1, 8,      wd(1),    1, 16));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 0,    1, 1, 8,      wd(1),    0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 1, 8,      wd(1),    0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 1, 12,     wd(2),    1, 20));
        vecs.push_back(mk(0, 0, 0,        0, 1, 16,     wd(3),    1, 24));
        vecs.push_back(mk(0, 0, 0,        0, 1, 20,     wd(4),    1, 28));
        vecs.push_back(mk(0, 0, 0,        0, 1, 24,     wd(5),    1, 32));
        vecs.push_back(mk(0, 0, 0,        1, 1, 28,     wd(6),    1, 36));
        vecs.push_back(mk(0, 1, 32'h43,   0, 1, 28,     wd(6),    0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,      0,        1, 32'h40));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,      0,        1, 32'h44));
        vecs.push_back(mk(0, 1, 32'h80,   1, 1, 32'h44, wd(16),   0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,      0,        1, 32'h80));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,      0,        1, 32'h84));
        vecs.push_back(mk(0, 0, 0,        0, 1, 32'h84, wd(32),   1, 32'h88));
        vecs.push_back(mk(0, 0, 0,        0, 1, 32'h88, wd(33),   1, 32'h8C));
        vecs.push_back(mk(0, 1, 32'h100,  0, 1, 32'h8C, wd(34),   0, 0));
        vecs.push_back(mk(0, 1, 32'h203,  0, 0, 0,      0,        0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,      0,        1, 32'h200));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,      0,        1, 32'h204));
        vecs.push_back(mk(0, 0, 0,        0, 1, 32'h204, wd(128), 1, 32'h208));
        vecs.push_back(mk(0, 0, 0,        1, 1, 32'h208, wd(129), 1, 32'h20C));
        vecs.push_back(mk(0, 0, 0,        1, 1, 32'h208, wd(129), 1, 32'h210));
        vecs.push_back(mk(1, 0, 0,        0, 0, 0,      0,        0, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,      0,        1, 0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,      0,        1, 4));
        vecs.push_back(mk(0, 0, 0,        0, 1, 4,      wd(0),    1, 8));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; br = vecs[i].br; br_pc = vecs[i].br_pc; stall = vecs[i].stall;
            @(negedge clk);
            check($sformatf("vec%0d valid", i), {31'b0, valid_a}, {31'b0, vecs[i].e_valid});
            check($sformatf("vec%0d pc", i), pc_a, vecs[i].e_pc);
            check($sformatf("vec%0d ins", i), ins_a, vecs[i].e_ins);
            check($sformatf("vec%0d rd_en", i), {31'b0, rd_en_a}, {31'b0, vecs[i].e_rd_en});
            if (vecs[i].e_rd_en)
                check($sformatf("vec%0d addr", i), addr_a, vecs[i].e_addr);
            @(posedge clk); #1;
        end

        // Address wrap on the instance reset to 0xFFFF_FFF8.
        wrap_addr[0] = 32'hFFFF_FFF8; wrap_pc[0] = 0;            wrap_ins[0] = 0;
        wrap_addr[1] = 32'hFFFF_FFFC; wrap_pc[1] = 0;            wrap_ins[1] = 0;
        wrap_addr[2] = 32'h0000_0000; wrap_pc[2] = 32'hFFFF_FFFC; wrap_ins[2] = 32'h4FFF_FFFE;
        wrap_addr[3] = 32'h0000_0004; wrap_pc[3] = 32'h0000_0000; wrap_ins[3] = 32'h4FFF_FFFF;
        wrap_addr[4] = 32'h0000_0008; wrap_pc[4] = 32'h0000_0004; wrap_ins[4] = 32'h1000_0000;
        rst = 1; br = 0; br_pc = 0; stall = 0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("wrap%0d rd_en", c), {31'b0, rd_en_b}, 32'd1);
            check($sformatf("wrap%0d addr", c), addr_b, wrap_addr[c]);
            check($sformatf("wrap%0d valid", c), {31'b0, valid_b}, {31'b0, (c >= 2)});
            check($sformatf("wrap%0d pc", c), pc_b, wrap_pc[c]);
            check($sformatf("wrap%0d ins", c), ins_b, wrap_ins[c]);
            @(posedge clk); #1;
        end

        // Randomized run against the queue model; first cycle resets both.
        for (int i = 0; i < 3000; i++) begin
            rst   = (i == 0) || ($urandom_range(0, 99) == 0);
            br    = ($urandom_range(0, 9) == 0);
            br_pc = $urandom();
            stall = ($urandom_range(0, 2) == 0);
            if (i > 0) begin
                ev = !rst && (mq.size() > 0);
                ep = ev ? mq[0].pc : 32'h0;
                ei = ev ? mq[0].ins : 32'h0;
                er = !rst && !br && ((mq.size() + int'(m_inflight)) < DEPTH);
                ea = m_fetch;
            end
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("rnd%0d valid", i), {31'b0, valid_a}, {31'b0, ev});
                check($sformatf("rnd%0d pc", i), pc_a, ep);
                check($sformatf("rnd%0d ins", i), ins_a, ei);
                check($sformatf("rnd%0d rd_en", i), {31'b0, rd_en_a}, {31'b0, er});
                if (er)
                    check($sformatf("rnd%0d addr", i), addr_a, ea);
            end
            @(posedge clk);
            model_step(rst, br, br_pc, stall);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
